mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

- Shares the single unified memory port between the instruction fetch stage and the data memory stage.
- One transaction is outstanding at a time.
- The data side has priority by default. An optional fairness counter bounds instruction-side starvation.
- Sits between the two pipeline stages and the memory interface. It drives the fetch-side ready/stall so fetch can hold its last PC.

## Interface
- ADDR_W, 32, address width, both requesters and memory
- DATA_W, 32, data width
- STARVE_LIMIT, 4, max consecutive data grants while an instruction request waits (fairness build only)
- iClk  in  1  clock; all state updates on rising edge
- iRst  in  1  reset, asynchronous, active-high
- iInstrValid  in  1  fetch request pending
- iInstrAddr  in  ADDR_W  fetch address
- oInstrReady  out  1  one-cycle pulse: fetch data valid
- oInstrData  out  DATA_W  fetch data, valid when oInstrReady
- oFetchStall  out  1  high while iInstrValid is pending and not completing this cycle
- iDataValid  in  1  data request pending
- iDataWrite  in  1  1 = write, 0 = read
- iDataAddr  in  ADDR_W  data address
- iDataWrData  in  DATA_W  write data
- oDataReady  out  1  one-cycle pulse: data access complete
- oDataRdData  out  DATA_W  read data, valid when oDataReady and read
- oMemValid  out  1  request to memory
- oMemWrite  out  1  memory write enable
- oMemAddr  out  ADDR_W  memory address
- oMemWrData  out  DATA_W  memory write data
- iMemReady  in  1  memory completes current access
- iMemData  in  DATA_W  memory read data

## Operation
- FSM states: IDLE, IBUSY, DBUSY. Encoding lives in the package.
- **Arbitration point:** evaluated in IDLE and in any BUSY cycle where iMemReady=1.
  - Data pending: grant data (next DBUSY).
  - Else instruction pending: grant instruction (next IBUSY).
  - Else: next IDLE.
- **Grant latching:** at grant, the winner's address, write flag and write data are registered. oMem* are driven from these registers only. Requester changes after grant do not affect the transaction.
- **Requester rules:** each requester holds valid and operands stable until its ready pulse. Deasserting valid before ready is illegal; the arbiter still completes the latched access.
- **Completion:** in IBUSY/DBUSY with iMemReady=1:
  - Pulse the matching ready.
  - Pass iMemData combinationally to oInstrData / oDataRdData.
  - Re-arbitrate the same cycle. No bubble between back-to-back transactions.
- **Stall output:** oFetchStall = iInstrValid & ~oInstrReady.
- **Ignored memory ready:** iMemReady in IDLE is ignored.
- **Read data when idle:** oDataRdData and oInstrData read 0 when their ready is low.

## Timing
- **Reset values:** state IDLE; oMemValid, oMemWrite, oInstrReady, oDataReady = 0; oMemAddr, oMemWrData, oInstrData, oDataRdData = 0; starve counter 0.
- **Reset mid-transaction:** the in-flight access is abandoned and no ready pulse is issued. The requester must re-request.
- **Latency:** request seen in IDLE at cycle N, so oMemValid=1 at N+1. With a zero-wait memory (iMemReady at N+1), ready pulses at N+1. Minimum 1 cycle; otherwise 1 + memory wait states.
- **oMemValid** is high for every cycle of IBUSY/DBUSY, including the ready cycle.
- **Simultaneous requests in IDLE:** data first; instruction is served at the data completion cycle if no new data request is pending (subject to fairness).

## Configuration
- **ARB_FAIRNESS_EN defined:** a saturating counter (width clog2(STARVE_LIMIT+1)) tracks data grants while iInstrValid is high.
  - Increments on each data grant made with iInstrValid=1.
  - Clears on any instruction grant or when iInstrValid=0.
  - When the count equals STARVE_LIMIT and both requests are pending, the instruction is granted.
- **ARB_FAIRNESS_EN undefined:** strict data priority; no counter logic exists. STARVE_LIMIT is unused.

## Structure
- **Shared package (mem_arb_pkg):** state encoding, requester ID enum (REQ_INSTR, REQ_DATA), default widths.
- **Sub-module mem_arb_starve_cnt:** the fairness counter, instantiated only under ARB_FAIRNESS_EN.
- FSM and grant registers stay in the top module.

## Test plan
- **Lone fetch:** iInstrValid=1, addr 0x10, memory ready after 2 waits, data 0xDEADBEEF -> oMemAddr=0x10 for 3 cycles; oInstrReady pulse with 0xDEADBEEF; oFetchStall high for the first 2 cycles.
- **Collision:** both valid in IDLE; data write addr 0x20, data 0x55; fetch addr 0x04; zero-wait memory -> write to 0x20 first, fetch at 0x04 the next cycle with no idle cycle between.
- **Fairness:** ARB_FAIRNESS_EN, STARVE_LIMIT=4, data valid continuously plus fetch pending -> exactly 4 data grants, then 1 instruction grant, pattern repeats. Without the macro: fetch never granted.
- **Address latching:** data requester changes iDataAddr from 0x30 to 0x40 mid-transaction -> oMemAddr stays 0x30 until ready.
- **Reset mid-access:** iRst asserted in DBUSY -> outputs 0 asynchronously, no oDataReady. After release with iDataValid still high, a new grant starts 1 cycle later.
- **Stray ready:** iMemReady pulsed in IDLE with no requests -> no ready outputs, state stays IDLE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory port arbiter: FSM encoding, requester IDs,
// default widths and the priority pick used at every arbitration point.
package mem_arb_pkg;

  localparam int unsigned DEF_ADDR_W       = 32;
  localparam int unsigned DEF_DATA_W       = 32;
  localparam int unsigned DEF_STARVE_LIMIT = 4;

  localparam int unsigned STATE_W = 2;
  localparam logic [1:0]  ST_IDLE  = 2'd0;
  localparam logic [1:0]  ST_IBUSY = 2'd1;
  localparam logic [1:0]  ST_DBUSY = 2'd2;

  typedef enum logic {
    REQ_INSTR = 1'b0,
    REQ_DATA  = 1'b1
  } reqId_t;

  // Data wins unless the starvation limit has been reached with fetch waiting.
  function automatic reqId_t pickWinner(input logic dataValid,
                                        input logic instrValid,
                                        input logic favorInstr);
    return (dataValid && !(favorInstr && instrValid)) ? REQ_DATA : REQ_INSTR;
  endfunction

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Saturating count of data grants made while a fetch request waits.
// Built into the arbiter only when ARB_FAIRNESS_EN is defined.
module mem_arb_starve_cnt
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iInstrValid,
  input  logic iDataGrant,
  input  logic iInstrGrant,
  output logic oLimitHit
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      cnt <= '0;
    end else if (iInstrGrant || !iInstrValid) begin
      cnt <= '0;
    end else if (iDataGrant && (cnt != LIMIT)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign oLimitHit = (cnt == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access, data first.
// Define ARB_FAIRNESS_EN to bound fetch starvation at STARVE_LIMIT data grants.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iInstrValid,
  input  logic [ADDR_W-1:0] iInstrAddr,
  output logic              oInstrReady,
  output logic [DATA_W-1:0] oInstrData,
  output logic              oFetchStall,
  input  logic              iDataValid,
  input  logic              iDataWrite,
  input  logic [ADDR_W-1:0] iDataAddr,
  input  logic [DATA_W-1:0] iDataWrData,
  output logic              oDataReady,
  output logic [DATA_W-1:0] oDataRdData,
  output logic              oMemValid,
  output logic              oMemWrite,
  output logic [ADDR_W-1:0] oMemAddr,
  output logic [DATA_W-1:0] oMemWrData,
  input  logic              iMemReady,
  input  logic [DATA_W-1:0] iMemData
);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] nextState;
  logic               arbPoint;
  logic               grantData;
  logic               grantInstr;
  logic               favorInstr;
  reqId_t             winner;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state <= ST_IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Arbitrate in IDLE and on every completion cycle so transfers chain without a bubble.
  always_comb begin
    nextState  = state;
    grantData  = 1'b0;
    grantInstr = 1'b0;
    winner     = REQ_DATA;
    arbPoint   = ((state == ST_IBUSY) || (state == ST_DBUSY)) ? iMemReady : 1'b1;
    if (arbPoint) begin
      nextState = ST_IDLE;
      if (iDataValid || iInstrValid) begin
        winner     = pickWinner(iDataValid, iInstrValid, favorInstr);
        grantData  = (winner == REQ_DATA);
        grantInstr = (winner == REQ_INSTR);
        nextState  = grantData ? ST_DBUSY : ST_IBUSY;
      end
    end
  end

  // The memory side sees only the operands captured at grant time.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      oMemValid  <= 1'b0;
      oMemWrite  <= 1'b0;
      oMemAddr   <= '0;
      oMemWrData <= '0;
    end else if (grantData) begin
      oMemValid  <= 1'b1;
      oMemWrite  <= iDataWrite;
      oMemAddr   <= iDataAddr;
      oMemWrData <= iDataWrData;
    end else if (grantInstr) begin
      oMemValid  <= 1'b1;
      oMemWrite  <= 1'b0;
      oMemAddr   <= iInstrAddr;
      oMemWrData <= '0;
    end else if (arbPoint) begin
      oMemValid  <= 1'b0;
      oMemWrite  <= 1'b0;
      oMemAddr   <= '0;
      oMemWrData <= '0;
    end
  end

  assign oInstrReady = (state == ST_IBUSY) && iMemReady;
  assign oDataReady  = (state == ST_DBUSY) && iMemReady;
  assign oInstrData  = oInstrReady ? iMemData : '0;
  assign oDataRdData = oDataReady ? iMemData : '0;
  assign oFetchStall = iInstrValid && !oInstrReady;

`ifdef ARB_FAIRNESS_EN
  mem_arb_starve_cnt #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) uStarveCnt (
    .iClk       (iClk),
    .iRst       (iRst),
    .iInstrValid(iInstrValid),
    .iDataGrant (grantData),
    .iInstrGrant(grantInstr),
    .oLimitHit  (favorInstr)
  );
`else
  logic unusedLimit;
  assign favorInstr  = 1'b0;
  assign unusedLimit = ^STARVE_LIMIT;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; fairness expectations follow ARB_FAIRNESS_EN.
module tb_mem_port_arbiter;

`ifdef ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iInstrValid;
  logic [31:0] iInstrAddr;
  logic        oInstrReady;
  logic [31:0] oInstrData;
  logic        oFetchStall;
  logic        iDataValid;
  logic        iDataWrite;
  logic [31:0] iDataAddr;
  logic [31:0] iDataWrData;
  logic        oDataReady;
  logic [31:0] oDataRdData;
  logic        oMemValid;
  logic        oMemWrite;
  logic [31:0] oMemAddr;
  logic [31:0] oMemWrData;
  logic        iMemReady;
  logic [31:0] iMemData;

  int nCompared = 0;
  int nFailed   = 0;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)
  ) dut (
    .iClk(iClk), .iRst(iRst),
    .iInstrValid(iInstrValid), .iInstrAddr(iInstrAddr),
    .oInstrReady(oInstrReady), .oInstrData(oInstrData), .oFetchStall(oFetchStall),
    .iDataValid(iDataValid), .iDataWrite(iDataWrite), .iDataAddr(iDataAddr),
    .iDataWrData(iDataWrData), .oDataReady(oDataReady), .oDataRdData(oDataRdData),
    .oMemValid(oMemValid), .oMemWrite(oMemWrite), .oMemAddr(oMemAddr),
    .oMemWrData(oMemWrData), .iMemReady(iMemReady), .iMemData(iMemData)
  );

  always #5 iClk = ~iClk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nFailed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Step to just after the next rising edge; inputs are then driven, checks follow #1 later.
  task automatic next();
    @(posedge iClk);
    #2;
  endtask

  task automatic drain();
    next();
    iInstrValid = 1'b0;
    iDataValid  = 1'b0;
    iMemReady   = 1'b1;
    next();
    iMemReady = 1'b0;
    #1;
    check("drain_idle", 32'(oMemValid), 32'd0);
  endtask

  initial begin
    logic expI;
    iRst = 1'b1;
    iInstrValid = 1'b0; iInstrAddr = '0;
    iDataValid = 1'b0; iDataWrite = 1'b0; iDataAddr = '0; iDataWrData = '0;
    iMemReady = 1'b1; iMemData = 32'hFFFF_FFFF;
    #2;
    check("rst_memvalid", 32'(oMemValid), 32'd0);
    check("rst_memwrite", 32'(oMemWrite), 32'd0);
    check("rst_memaddr", oMemAddr, 32'd0);
    check("rst_wrdata", oMemWrData, 32'd0);
    check("rst_instrready", 32'(oInstrReady), 32'd0);
    check("rst_dataready", 32'(oDataReady), 32'd0);
    check("rst_instrdata", oInstrData, 32'd0);
    check("rst_rddata", oDataRdData, 32'd0);
    next();
    iRst = 1'b0;
    iMemReady = 1'b0;

    // Stray ready in IDLE
    next();
    iMemReady = 1'b1; iMemData = 32'h0000_1234;
    #1;
    check("stray_instrready", 32'(oInstrReady), 32'd0);
    check("stray_dataready", 32'(oDataReady), 32'd0);
    check("stray_instrdata", oInstrData, 32'd0);
    check("stray_rddata", oDataRdData, 32'd0);
    next();
    iMemReady = 1'b0;
    #1;
    check("stray_idle", 32'(oMemValid), 32'd0);

    // Lone fetch with two wait states
    next();
    iInstrValid = 1'b1; iInstrAddr = 32'h10;
    #1;
    check("fetch_req_stall", 32'(oFetchStall), 32'd1);
    check("fetch_req_memvalid", 32'(oMemValid), 32'd0);
    next();
    #1;
    check("fetch_w1_memvalid", 32'(oMemValid), 32'd1);
    check("fetch_w1_addr", oMemAddr, 32'h10);
    check("fetch_w1_write", 32'(oMemWrite), 32'd0);
    check("fetch_w1_stall", 32'(oFetchStall), 32'd1);
    check("fetch_w1_ready", 32'(oInstrReady), 32'd0);
    next();
    #1;
    check("fetch_w2_addr", oMemAddr, 32'h10);
    check("fetch_w2_stall", 32'(oFetchStall), 32'd1);
    next();
    iMemReady = 1'b1; iMemData = 32'hDEAD_BEEF;
    #1;
    check("fetch_done_ready", 32'(oInstrReady), 32'd1);
    check("fetch_done_data", oInstrData, 32'hDEAD_BEEF);
    check("fetch_done_stall", 32'(oFetchStall), 32'd0);
    check("fetch_done_addr", oMemAddr, 32'h10);
    check("fetch_done_memvalid", 32'(oMemValid), 32'd1);
    check("fetch_done_dready", 32'(oDataReady), 32'd0);
    drain();

    // Collision: data write first, fetch back-to-back
    next();
    iInstrValid = 1'b1; iInstrAddr = 32'h04;
    iDataValid = 1'b1; iDataWrite = 1'b1; iDataAddr = 32'h20; iDataWrData = 32'h55;
    iMemReady = 1'b0;
    #1;
    check("coll_req_stall", 32'(oFetchStall), 32'd1);
    next();
    iDataValid = 1'b0; iMemReady = 1'b1; iMemData = 32'h0;
    #1;
    check("coll_d_memvalid", 32'(oMemValid), 32'd1);
    check("coll_d_write", 32'(oMemWrite), 32'd1);
    check("coll_d_addr", oMemAddr, 32'h20);
    check("coll_d_wrdata", oMemWrData, 32'h55);
    check("coll_d_dready", 32'(oDataReady), 32'd1);
    check("coll_d_iready", 32'(oInstrReady), 32'd0);
    check("coll_d_stall", 32'(oFetchStall), 32'd1);
    next();
    iInstrValid = 1'b0; iMemData = 32'hCAFE_0004;
    #1;
    check("coll_i_memvalid", 32'(oMemValid), 32'd1);
    check("coll_i_write", 32'(oMemWrite), 32'd0);
    check("coll_i_addr", oMemAddr, 32'h04);
    check("coll_i_iready", 32'(oInstrReady), 32'd1);
    check("coll_i_idata", oInstrData, 32'hCAFE_0004);
    next();
    iMemReady = 1'b0;
    #1;
    check("coll_idle", 32'(oMemValid), 32'd0);

    // Address latching across a requester change
    next();
    iDataValid = 1'b1; iDataWrite = 1'b0; iDataAddr = 32'h30;
    #1;
    next();
    iDataAddr = 32'h40;
    #1;
    check("latch_w1_addr", oMemAddr, 32'h30);
    check("latch_w1_write", 32'(oMemWrite), 32'd0);
    next();
    #1;
    check("latch_w2_addr", oMemAddr, 32'h30);
    next();
    iDataValid = 1'b0; iMemReady = 1'b1; iMemData = 32'hA5A5_0030;
    #1;
    check("latch_done_addr", oMemAddr, 32'h30);
    check("latch_done_dready", 32'(oDataReady), 32'd1);
    check("latch_done_rddata", oDataRdData, 32'hA5A5_0030);
    check("latch_done_idata", oInstrData, 32'd0);
    next();
    iMemReady = 1'b0;
    #1;
    check("latch_idle", 32'(oMemValid), 32'd0);

    // Reset in the middle of a data access
    next();
    iDataValid = 1'b1; iDataWrite = 1'b1; iDataAddr = 32'h50; iDataWrData = 32'h77;
    #1;
    next();
    #1;
    check("rmid_busy", 32'(oMemValid), 32'd1);
    #1;
    iRst = 1'b1; iMemReady = 1'b1;
    #1;
    check("rmid_memvalid", 32'(oMemValid), 32'd0);
    check("rmid_memaddr", oMemAddr, 32'd0);
    check("rmid_memwrite", 32'(oMemWrite), 32'd0);
    check("rmid_wrdata", oMemWrData, 32'd0);
    check("rmid_dready", 32'(oDataReady), 32'd0);
    next();
    iRst = 1'b0; iMemReady = 1'b0;
    #1;
    check("rmid_rel_idle", 32'(oMemValid), 32'd0);
    next();
    #1;
    check("rmid_regrant_valid", 32'(oMemValid), 32'd1);
    check("rmid_regrant_addr", oMemAddr, 32'h50);
    check("rmid_regrant_write", 32'(oMemWrite), 32'd1);
    next();
    iDataValid = 1'b0; iMemReady = 1'b1;
    #1;
    check("rmid_done_dready", 32'(oDataReady), 32'd1);
    next();
    iMemReady = 1'b0;
    #1;
    check("rmid_idle", 32'(oMemValid), 32'd0);

    // Continuous data traffic with a waiting fetch
    next();
    iDataValid = 1'b1; iDataWrite = 1'b0; iDataAddr = 32'h100;
    iInstrValid = 1'b1; iInstrAddr = 32'h200;
    iMemReady = 1'b1; iMemData = 32'h600D_0000;
    #1;
    check("fair_start_memvalid", 32'(oMemValid), 32'd0);
    for (int k = 1; k <= 10; k++) begin
      next();
      #1;
      expI = FAIR && ((k % 5) == 0);
      check($sformatf("fair_c%0d_iready", k), 32'(oInstrReady), 32'(expI));
      check($sformatf("fair_c%0d_dready", k), 32'(oDataReady), 32'(!expI));
      check($sformatf("fair_c%0d_addr", k), oMemAddr, expI ? 32'h200 : 32'h100);
      check($sformatf("fair_c%0d_stall", k), 32'(oFetchStall), 32'(!expI));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

endmodule
